// File: rtl/fb_pkg.sv
// Shared definitions for the banked frame buffer: writer state encoding and
// elaboration-time sizing helpers.
package fb_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_FULL = 2'd2
   } wr_state_t;

   localparam logic [7:0] DROP_MAX = 8'd255;

   function automatic int fb_clog2(input longint v);
      int r;
      r = 0;
      while ((longint'(1) << r) < v) r++;
      return r;
   endfunction

   function automatic int pix_count(input int w, input int h);
      return w * h;
   endfunction

   function automatic int num_banks(input longint total, input int aw);
      return int'((total + (longint'(1) << aw) - 1) >> aw);
   endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One frame-buffer bank: simple dual-port synchronous RAM with registered read.
// A read and write to the same word on the same edge returns the old word.
module fb_bank_ram #(
   parameter int AW = 16,
   parameter int DW = 12
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer_banked.sv
// Banked, optionally double-buffered frame store between capture (writer) and
// display/processing (reader). Pages swap at reader start-of-frame.
//
//   state  | meaning
//   W_IDLE | waiting for wr_sof, writes ignored
//   W_FILL | accepting pixels at the auto-incrementing pointer
//   W_FULL | back page holds an unconsumed frame, wr_sof counted as a drop
module frame_buffer_banked
   import fb_pkg::*;
#(
   parameter int PIX_W      = 12,
   parameter int FRAME_W    = 320,
   parameter int FRAME_H    = 240,
   parameter int BANK_AW    = 16,
   parameter int DOUBLE_BUF = 1,
   parameter int ADDR_W     = 17
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_wr_sof,
   input  logic              i_wr_valid,
   input  logic [PIX_W-1:0]  i_wr_data,
   output logic              o_wr_frame_done,
   output logic [7:0]        o_wr_drop_cnt,
   input  logic              i_rd_sof,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_valid,
   output logic [PIX_W-1:0]  o_rd_data,
   output logic              o_frame_avail
);

   localparam int PIX_COUNT = pix_count(FRAME_W, FRAME_H);
   localparam int NUM_PAGES = (DOUBLE_BUF != 0) ? 2 : 1;
   localparam int NUM_BANKS = num_banks(longint'(PIX_COUNT) * NUM_PAGES, BANK_AW);
   localparam int BSEL_W    = (NUM_BANKS > 1) ? fb_clog2(NUM_BANKS) : 1;
   localparam int PADDR_W   = BANK_AW + BSEL_W;
   localparam logic [PADDR_W-1:0] PAGE_OFS = PADDR_W'(PIX_COUNT);
   localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(PIX_COUNT - 1);

   wr_state_t         r_wstate, w_wstate_nxt;
   logic [ADDR_W-1:0] r_wptr, w_wptr_nxt, w_wr_pix;
   logic              r_wr_page, r_rd_page, r_ready, r_frame_avail, r_frame_done;
   logic [7:0]        r_drop_cnt;
   logic              w_wr_en, w_done, w_drop_inc, w_swap;

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wptr_nxt   = r_wptr;
      w_wr_pix     = r_wptr;
      w_wr_en      = 1'b0;
      w_done       = 1'b0;
      w_drop_inc   = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (i_wr_sof) begin
               w_wstate_nxt = W_FILL;
               w_wptr_nxt   = '0;
               w_wr_pix     = '0;
               w_wr_en      = i_wr_valid;
            end
         end
         W_FILL: begin
            if (i_wr_sof) begin
               w_wptr_nxt = '0;
               w_wr_pix   = '0;
            end
            w_wr_en = i_wr_valid;
         end
         W_FULL:  w_drop_inc = i_wr_sof;
         default: w_wstate_nxt = W_IDLE;
      endcase
      if (w_wr_en) begin
         w_wptr_nxt = w_wr_pix + 1'b1;
         if (w_wr_pix == LAST_PIX) begin
            w_done       = 1'b1;
            w_wptr_nxt   = '0;
            w_wstate_nxt = (DOUBLE_BUF != 0) ? W_FULL : W_IDLE;
         end
      end
      // A frame finishing in the same cycle as rd_sof is handed over immediately.
      w_swap = (DOUBLE_BUF != 0) && i_rd_sof && (r_ready || w_done);
      if (w_swap) w_wstate_nxt = W_IDLE;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wstate      <= W_IDLE;
         r_wptr        <= '0;
         r_wr_page     <= 1'b0;
         r_rd_page     <= (DOUBLE_BUF != 0);
         r_ready       <= 1'b0;
         r_frame_avail <= 1'b0;
         r_frame_done  <= 1'b0;
         r_drop_cnt    <= '0;
      end else begin
         r_wstate     <= w_wstate_nxt;
         r_wptr       <= w_wptr_nxt;
         r_frame_done <= w_done;
         if (w_drop_inc && (r_drop_cnt != DROP_MAX)) r_drop_cnt <= r_drop_cnt + 8'd1;
         if (w_swap) begin
            r_rd_page     <= r_wr_page;
            r_wr_page     <= ~r_wr_page;
            r_ready       <= 1'b0;
            r_frame_avail <= 1'b1;
         end else if (w_done) begin
            r_ready <= (DOUBLE_BUF != 0);
            if (DOUBLE_BUF == 0) r_frame_avail <= 1'b1;
         end
      end
   end

   logic [PADDR_W-1:0] w_wpaddr, w_rpaddr;
   logic               w_rd_page, w_rd_oor;
   logic [PIX_W-1:0]   w_bank_q [NUM_BANKS];
   logic [PIX_W-1:0]   w_rd_mux;
   logic               r_rd_v1, r_rd_oor1, r_rd_valid;
   logic [BSEL_W-1:0]  r_rd_bsel1;
   logic [PIX_W-1:0]   r_rd_data;

   assign w_rd_page = w_swap ? r_wr_page : r_rd_page;
   assign w_rd_oor  = {1'b0, i_rd_addr} >= (ADDR_W + 1)'(PIX_COUNT);
   assign w_wpaddr  = (r_wr_page ? PAGE_OFS : '0) + PADDR_W'(w_wr_pix);
   assign w_rpaddr  = (w_rd_page ? PAGE_OFS : '0) + PADDR_W'(i_rd_addr);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      fb_bank_ram #(.AW(BANK_AW), .DW(PIX_W)) u_ram (
         .i_clk   (i_clock),
         .i_we    (w_wr_en && (w_wpaddr[PADDR_W-1:BANK_AW] == BSEL_W'(b))),
         .i_waddr (w_wpaddr[BANK_AW-1:0]),
         .i_wdata (i_wr_data),
         .i_re    (i_rd_en && !w_rd_oor && (w_rpaddr[PADDR_W-1:BANK_AW] == BSEL_W'(b))),
         .i_raddr (w_rpaddr[BANK_AW-1:0]),
         .o_rdata (w_bank_q[b])
      );
   end

   always_comb begin
      w_rd_mux = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_rd_bsel1 == BSEL_W'(b)) w_rd_mux = w_bank_q[b];
      end
   end

   // Bank select and range flag travel alongside the RAM read stage.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_rd_v1    <= 1'b0;
         r_rd_oor1  <= 1'b0;
         r_rd_bsel1 <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_v1    <= i_rd_en;
         r_rd_oor1  <= w_rd_oor;
         r_rd_bsel1 <= w_rpaddr[PADDR_W-1:BANK_AW];
         r_rd_valid <= r_rd_v1;
         if (r_rd_v1) r_rd_data <= r_rd_oor1 ? '0 : w_rd_mux;
      end
   end

   assign o_wr_frame_done = r_frame_done;
   assign o_wr_drop_cnt   = r_drop_cnt;
   assign o_rd_valid      = r_rd_valid;
   assign o_rd_data       = r_rd_data;
   assign o_frame_avail   = r_frame_avail;

endmodule

// File: tb/tb_frame_buffer_banked.sv
// Bench for frame_buffer_banked on a reduced 16x8 frame with 64-word banks:
// a frame-level model checks the double-buffered instance every cycle, and a
// single-page instance is checked with directed values.
module tb_frame_buffer_banked;

   localparam int FW  = 16;
   localparam int FH  = 8;
   localparam int PIX = FW * FH;
   localparam int BAW = 6;
   localparam int AW  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_sof = 1'b0, wr_valid = 1'b0, rd_sof = 1'b0, rd_en = 1'b0;
   logic [11:0] wr_data = '0;
   logic [7:0]  rd_addr = '0;
   logic        o_done, o_rvalid, o_avail;
   logic [7:0]  o_drop;
   logic [11:0] o_rdata;

   logic        s_wr_sof = 1'b0, s_wr_valid = 1'b0, s_rd_sof = 1'b0, s_rd_en = 1'b0;
   logic [11:0] s_wr_data = '0;
   logic [7:0]  s_rd_addr = '0;
   logic        s_done, s_rvalid, s_avail;
   logic [7:0]  s_drop;
   logic [11:0] s_rdata;

   int total = 0;
   int bad = 0;
   int done_seen = 0;

   always #5 clk = ~clk;

   frame_buffer_banked #(.PIX_W(12), .FRAME_W(FW), .FRAME_H(FH), .BANK_AW(BAW),
                         .DOUBLE_BUF(1), .ADDR_W(AW)) u_dut (
      .i_clock(clk), .i_reset(rst),
      .i_wr_sof(wr_sof), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
      .o_wr_frame_done(o_done), .o_wr_drop_cnt(o_drop),
      .i_rd_sof(rd_sof), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_valid(o_rvalid), .o_rd_data(o_rdata), .o_frame_avail(o_avail));

   frame_buffer_banked #(.PIX_W(12), .FRAME_W(FW), .FRAME_H(FH), .BANK_AW(BAW),
                         .DOUBLE_BUF(0), .ADDR_W(AW)) u_single (
      .i_clock(clk), .i_reset(rst),
      .i_wr_sof(s_wr_sof), .i_wr_valid(s_wr_valid), .i_wr_data(s_wr_data),
      .o_wr_frame_done(s_done), .o_wr_drop_cnt(s_drop),
      .i_rd_sof(s_rd_sof), .i_rd_en(s_rd_en), .i_rd_addr(s_rd_addr),
      .o_rd_valid(s_rvalid), .o_rd_data(s_rdata), .o_frame_avail(s_avail));

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] idx_data(input int i);
      return 12'(i + 'hF80);
   endfunction

   // Frame-level model: two pages, who owns which, and a one-deep read delay line.
   logic [11:0] m_mem [2][PIX];
   bit          m_rpage = 1, m_wpage = 0, m_filling = 0, m_full = 0;
   int          m_ptr = 0;
   bit          p_valid = 0;
   logic [11:0] p_data = '0;
   bit          e_valid = 0, e_done = 0, e_avail = 0;
   logic [11:0] e_data = '0;
   int          e_drop = 0;

   task automatic model_step();
      bit last, do_wr, swap, pg;
      int pix;
      logic [11:0] rd_val;
      if (rst) begin
         m_rpage = 1; m_wpage = 0; m_filling = 0; m_full = 0; m_ptr = 0;
         p_valid = 0; p_data = '0;
         e_valid = 0; e_data = '0; e_done = 0; e_avail = 0; e_drop = 0;
         return;
      end
      last = 0; do_wr = 0; pix = 0;
      if (m_full) begin
         if (wr_sof && e_drop < 255) e_drop++;
      end else begin
         if (wr_sof) begin m_filling = 1; m_ptr = 0; end
         if (m_filling && wr_valid) begin
            do_wr = 1; pix = m_ptr; last = (pix == PIX - 1);
         end
      end
      swap = rd_sof && (m_full || last);
      pg = swap ? m_wpage : m_rpage;
      rd_val = (int'(rd_addr) >= PIX) ? 12'h000 : m_mem[pg][int'(rd_addr) % PIX];
      e_valid = p_valid;
      if (p_valid) e_data = p_data;
      p_valid = rd_en;
      p_data = rd_val;
      if (do_wr) begin
         m_mem[m_wpage][pix] = wr_data;
         m_ptr = pix + 1;
         if (last) begin m_filling = 0; m_full = 1; end
      end
      e_done = last;
      if (swap) begin
         m_rpage = m_wpage; m_wpage = !m_wpage; m_full = 0; e_avail = 1;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("m_rd_valid", o_rvalid, e_valid);
         chk("m_rd_data", o_rdata, e_data);
         chk("m_frame_done", o_done, e_done);
         chk("m_drop_cnt", o_drop, e_drop);
         chk("m_frame_avail", o_avail, e_avail);
         if (o_done) done_seen++;
      end
   end

   task automatic write_frame(input logic [11:0] val, input bit use_idx, input bit sof_last);
      for (int i = 0; i < PIX; i++) begin
         wr_sof = (i == 0);
         wr_valid = 1'b1;
         wr_data = use_idx ? idx_data(i) : val;
         if (sof_last && i == PIX - 1) begin
            rd_sof = 1'b1; rd_en = 1'b1; rd_addr = 8'd5;
         end
         @(negedge clk);
         wr_sof = 1'b0; wr_valid = 1'b0; rd_sof = 1'b0; rd_en = 1'b0;
      end
      chk("done_pulse", o_done, 1);
   endtask

   task automatic pulse_rd_sof();
      rd_sof = 1'b1;
      @(negedge clk);
      rd_sof = 1'b0;
   endtask

   task automatic read_chk(input int addr, input logic [11:0] exp, input string name);
      rd_en = 1'b1; rd_addr = 8'(addr);
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
      chk({name, "_valid"}, o_rvalid, 1);
      chk(name, o_rdata, exp);
   endtask

   task automatic s_read_chk(input int addr, input logic [11:0] exp, input string name);
      s_rd_en = 1'b1; s_rd_addr = 8'(addr);
      @(negedge clk);
      s_rd_en = 1'b0;
      @(negedge clk);
      chk({name, "_valid"}, s_rvalid, 1);
      chk(name, s_rdata, exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      repeat (2) @(negedge clk);
      chk("rst_rd_valid", o_rvalid, 0);
      chk("rst_rd_data", o_rdata, 0);
      chk("rst_done", o_done, 0);
      chk("rst_drop", o_drop, 0);
      chk("rst_avail", o_avail, 0);
      chk("rst_s_avail", s_avail, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: indexed frame, swap, bank-boundary reads, out-of-range read
      write_frame(12'h000, 1'b1, 1'b0);
      chk("t1_avail_before_sof", o_avail, 0);
      pulse_rd_sof();
      chk("t1_avail", o_avail, 1);
      read_chk(0, 12'hF80, "t1_rd0");
      read_chk(63, 12'hFBF, "t1_rd63");
      read_chk(64, 12'hFC0, "t1_rd64");
      read_chk(127, 12'hFFF, "t1_rd127");
      read_chk(200, 12'h000, "t1_rd_oor");

      // 2: ping-pong without and with rd_sof
      write_frame(12'h111, 1'b0, 1'b0);
      pulse_rd_sof();
      write_frame(12'h222, 1'b0, 1'b0);
      read_chk(10, 12'h111, "t2_old_page");
      pulse_rd_sof();
      read_chk(10, 12'h222, "t2_new_page");

      // 3: drops while full, then saturation
      write_frame(12'h333, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         wr_sof = 1'b1; wr_valid = 1'b1; wr_data = 12'h777;
         @(negedge clk);
         wr_sof = 1'b0;
         @(negedge clk);
         wr_valid = 1'b0;
      end
      chk("t3_drop3", o_drop, 3);
      pulse_rd_sof();
      read_chk(0, 12'h333, "t3_unchanged0");
      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1; rd_addr = 8'(a * 8);
         @(negedge clk);
      end
      rd_en = 1'b0;
      write_frame(12'h444, 1'b0, 1'b0);
      wr_sof = 1'b1; wr_valid = 1'b1;
      repeat (300) @(negedge clk);
      wr_sof = 1'b0; wr_valid = 1'b0;
      chk("t3_drop_sat", o_drop, 255);
      pulse_rd_sof();
      read_chk(127, 12'h444, "t3_after_sat");

      // 4: completion, rd_sof and rd_en together
      write_frame(12'h555, 1'b0, 1'b1);
      @(negedge clk);
      chk("t4_same_cycle_valid", o_rvalid, 1);
      chk("t4_same_cycle_data", o_rdata, 12'h555);
      pulse_rd_sof();
      read_chk(5, 12'h555, "t4_no_swap");

      // 5: restart mid-frame
      d0 = done_seen;
      for (int i = 0; i < 50; i++) begin
         wr_sof = (i == 0); wr_valid = 1'b1; wr_data = 12'h666;
         @(negedge clk);
      end
      wr_sof = 1'b0; wr_valid = 1'b0;
      chk("t5_no_done_partial", done_seen - d0, 0);
      write_frame(12'h777, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_one_done", done_seen - d0, 1);
      pulse_rd_sof();
      read_chk(0, 12'h777, "t5_rd0");
      read_chk(49, 12'h777, "t5_rd49");

      // 6: reset with reads in flight
      rd_en = 1'b1; rd_addr = 8'd1;
      @(negedge clk);
      rd_addr = 8'd2;
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", o_rvalid, 0);
      chk("t6_rst_avail", o_avail, 0);
      @(negedge clk);
      rd_en = 1'b0;
      chk("t6_rst_valid_held", o_rvalid, 0);
      chk("t6_rst_drop", o_drop, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single page build: avail on first completion without rd_sof
      for (int i = 0; i < PIX; i++) begin
         s_wr_sof = (i == 0); s_wr_valid = 1'b1; s_wr_data = 12'h0AB;
         if (i == PIX - 1) chk("s_avail_before", s_avail, 0);
         @(negedge clk);
      end
      s_wr_sof = 1'b0; s_wr_valid = 1'b0;
      chk("s_done", s_done, 1);
      chk("s_avail", s_avail, 1);
      s_read_chk(3, 12'h0AB, "s_rd3");
      s_wr_sof = 1'b1; s_wr_valid = 1'b1; s_wr_data = 12'h0CD;
      s_rd_en = 1'b1; s_rd_addr = 8'd0;
      @(negedge clk);
      s_wr_sof = 1'b0; s_wr_valid = 1'b0; s_rd_en = 1'b0;
      @(negedge clk);
      chk("s_rw_same_old", s_rdata, 12'h0AB);
      s_read_chk(0, 12'h0CD, "s_rw_new");
      chk("s_drop", s_drop, 0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
